// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared encodings for the P6 pipeline writeback path.
//            - wd_sel_e  : writeback data source select
//            - ld_type_e : load width / extension type
//            - PC_RESET  : PC presented by an empty (reset/flushed) W stage
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_PC8  = 2'd2,
    WD_HILO = 2'd3
  } wd_sel_e;

  // Codes 5-7 are unused and decode as a full-word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } ld_type_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module   : load_ext
// Purpose  : Combinational byte/halfword select and sign/zero extension of a
//            raw data-memory word.
// Ports    : raw     in  [31:0] aligned word read from data memory
//            addr_lo in  [1:0]  byte offset of the load address
//            ld_type in  [2:0]  load type (LW/LH/LHU/LB/LBU, others = LW)
//            result  out [31:0] extended load value
// Revision : 1.0 - initial release
// ============================================================================
module load_ext
  import pipe_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    // Halfword loads only look at addr_lo[1]; addr_lo[0] is ignored.
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    byte_sel = raw[7:0];
    case (addr_lo)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase

    result = raw;
    case (ld_type)
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0000, half_sel};
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h00_0000, byte_sel};
      default: result = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : M/W pipeline register and writeback-select logic. Captures the
//            M-stage result, extends load data, selects the writeback value
//            and drives the register-file write port (committed on negedge).
// Ports    : clk, reset (async active-low), en (capture), flush (bubble,
//            wins over en)
//            m_*        in  M-stage instruction fields
//            grf_a3/wd/we/pc  out register-file write port and W-stage PC
//            w_fwd_a3/wd      out forwarding view (a3 = 0 when no write)
//            retire_cnt       out valid instructions that reached W
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = pipe_pkg::PC_RESET,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic             m_we,
  input  logic [4:0]       m_a3,
  input  logic [1:0]       m_wd_sel,
  input  logic [31:0]      m_alu,
  input  logic [31:0]      m_dm_rdata,
  input  logic [1:0]       m_addr_lo,
  input  logic [2:0]       m_ld_type,
  input  logic [31:0]      m_hilo,
  output logic [4:0]       grf_a3,
  output logic [31:0]      grf_wd,
  output logic             grf_we,
  output logic [31:0]      grf_pc,
  output logic [4:0]       w_fwd_a3,
  output logic [31:0]      w_fwd_wd,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             valid_q;
  logic             we_q;
  logic [4:0]       a3_q;
  logic [1:0]       wd_sel_q;
  logic [31:0]      alu_q;
  logic [31:0]      rdata_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       ld_type_q;
  logic [31:0]      hilo_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      load_val;
  logic [31:0]      wd_mux;
  logic             write_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      a3_q      <= 5'd0;
      wd_sel_q  <= 2'd0;
      alu_q     <= 32'd0;
      rdata_q   <= 32'd0;
      addr_lo_q <= 2'd0;
      ld_type_q <= 3'd0;
      hilo_q    <= 32'd0;
      pc_q      <= PC_RESET;
      cnt_q     <= '0;
    end else if (flush) begin
      // Bubble: every data field zeroed so grf_wd reads 0 (ALU source, alu=0).
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      a3_q      <= 5'd0;
      wd_sel_q  <= 2'd0;
      alu_q     <= 32'd0;
      rdata_q   <= 32'd0;
      addr_lo_q <= 2'd0;
      ld_type_q <= 3'd0;
      hilo_q    <= 32'd0;
      pc_q      <= PC_RESET;
    end else if (en) begin
      valid_q   <= m_valid;
      we_q      <= m_we;
      a3_q      <= m_a3;
      wd_sel_q  <= m_wd_sel;
      alu_q     <= m_alu;
      rdata_q   <= m_dm_rdata;
      addr_lo_q <= m_addr_lo;
      ld_type_q <= m_ld_type;
      hilo_q    <= m_hilo;
      pc_q      <= m_pc;
      if (m_valid) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  load_ext u_load_ext (
    .raw     (rdata_q),
    .addr_lo (addr_lo_q),
    .ld_type (ld_type_q),
    .result  (load_val)
  );

  always_comb begin
    wd_mux = alu_q;
    case (wd_sel_q)
      WD_ALU:  wd_mux = alu_q;
      WD_MEM:  wd_mux = load_val;
      WD_PC8:  wd_mux = pc_q + 32'd8;
      WD_HILO: wd_mux = hilo_q;
      default: wd_mux = alu_q;
    endcase
  end

  // Writes to $0 are dropped here so the register file never sees them.
  assign write_en   = valid_q & we_q & (a3_q != 5'd0);

  assign grf_a3     = a3_q;
  assign grf_wd     = wd_mux;
  assign grf_we     = write_en;
  assign grf_pc     = pc_q;
  assign w_fwd_a3   = write_en ? a3_q : 5'd0;
  assign w_fwd_wd   = wd_mux;
  assign retire_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage. Directed steps from the test
//            plan followed by randomized traffic, compared against a
//            behavioural model of the W stage. A second instance with a
//            4-bit counter exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [1:0]  m_wd_sel;
  logic [31:0] m_alu;
  logic [31:0] m_dm_rdata;
  logic [1:0]  m_addr_lo;
  logic [2:0]  m_ld_type;
  logic [31:0] m_hilo;

  logic [4:0]  grf_a3,  grf_a3_4;
  logic [31:0] grf_wd,  grf_wd_4;
  logic        grf_we,  grf_we_4;
  logic [31:0] grf_pc,  grf_pc_4;
  logic [4:0]  w_fwd_a3, w_fwd_a3_4;
  logic [31:0] w_fwd_wd, w_fwd_wd_4;
  logic [31:0] retire_cnt;
  logic [3:0]  retire_cnt_4;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of what the W stage should be presenting.
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  logic        exp_we;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [3:0]  exp_cnt4;

  wb_stage #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we), .m_a3(m_a3),
    .m_wd_sel(m_wd_sel), .m_alu(m_alu), .m_dm_rdata(m_dm_rdata),
    .m_addr_lo(m_addr_lo), .m_ld_type(m_ld_type), .m_hilo(m_hilo),
    .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_we(grf_we), .grf_pc(grf_pc),
    .w_fwd_a3(w_fwd_a3), .w_fwd_wd(w_fwd_wd), .retire_cnt(retire_cnt)
  );

  wb_stage #(.PC_RESET(32'h0000_3000), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we), .m_a3(m_a3),
    .m_wd_sel(m_wd_sel), .m_alu(m_alu), .m_dm_rdata(m_dm_rdata),
    .m_addr_lo(m_addr_lo), .m_ld_type(m_ld_type), .m_hilo(m_hilo),
    .grf_a3(grf_a3_4), .grf_wd(grf_wd_4), .grf_we(grf_we_4), .grf_pc(grf_pc_4),
    .w_fwd_a3(w_fwd_a3_4), .w_fwd_wd(w_fwd_wd_4), .retire_cnt(retire_cnt_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load value from the architectural rules: shift the selected lane down,
  // mask it, then sign- or zero-extend.
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] lo, logic [2:0] t);
    logic [31:0] h;
    logic [31:0] b;
    h = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
    b = (w >> (8 * lo)) & 32'h0000_00FF;
    case (t)
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(logic [1:0] sel, logic [31:0] alu, logic [31:0] rd,
                                         logic [1:0] lo, logic [2:0] t, logic [31:0] pc,
                                         logic [31:0] hilo);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ref_load(rd, lo, t);
      2'd2:    return pc + 32'd8;
      default: return hilo;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a3"},     {27'd0, grf_a3},   {27'd0, exp_a3});
    chk({tag, ".wd"},     grf_wd,            exp_wd);
    chk({tag, ".we"},     {31'd0, grf_we},   {31'd0, exp_we});
    chk({tag, ".pc"},     grf_pc,            exp_pc);
    chk({tag, ".fwd_a3"}, {27'd0, w_fwd_a3}, {27'd0, (exp_we ? exp_a3 : 5'd0)});
    chk({tag, ".fwd_wd"}, w_fwd_wd,          exp_wd);
    chk({tag, ".cnt"},    retire_cnt,        exp_cnt);
    chk({tag, ".cnt4"},   {28'd0, retire_cnt_4}, {28'd0, exp_cnt4});
  endtask

  task automatic model_reset();
    exp_a3   = 5'd0;
    exp_wd   = 32'd0;
    exp_we   = 1'b0;
    exp_pc   = 32'h0000_3000;
    exp_cnt  = 32'd0;
    exp_cnt4 = 4'd0;
  endtask

  // Called at a negedge: apply inputs, let one posedge happen, update the
  // model, then compare at the following negedge.
  task automatic step(input string tag, input logic v, input logic we, input logic [4:0] a3,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rd,
                      input logic [1:0] lo, input logic [2:0] t, input logic [31:0] pc,
                      input logic [31:0] hilo, input logic e, input logic f);
    m_valid = v; m_we = we; m_a3 = a3; m_wd_sel = sel; m_alu = alu;
    m_dm_rdata = rd; m_addr_lo = lo; m_ld_type = t; m_pc = pc; m_hilo = hilo;
    en = e; flush = f;
    @(posedge clk);
    if (f) begin
      exp_a3 = 5'd0; exp_wd = 32'd0; exp_we = 1'b0; exp_pc = 32'h0000_3000;
    end else if (e) begin
      exp_a3 = a3;
      exp_wd = ref_wd(sel, alu, rd, lo, t, pc, hilo);
      exp_we = v && we && (a3 != 5'd0);
      exp_pc = pc;
      if (v) begin
        exp_cnt  = exp_cnt + 32'd1;
        exp_cnt4 = exp_cnt4 + 4'd1;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_pc = 32'd0; m_we = 1'b0; m_a3 = 5'd0; m_wd_sel = 2'd0;
    m_alu = 32'd0; m_dm_rdata = 32'd0; m_addr_lo = 2'd0; m_ld_type = 3'd0; m_hilo = 32'd0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // ALU write to $5
    step("alu", 1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'd0, 2'd0, 3'd0, 32'h0000_3000, 32'd0, 1, 0);
    chk("alu_const", grf_wd, 32'h1234_5678);

    // Async reset mid-cycle with a write pending
    en = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;

    // Loads from 0x80FF_7F01
    step("lb",  1, 1, 5'd8, 2'd1, 32'd0, 32'h80FF_7F01, 2'd3, 3'd3, 32'h3004, 32'd0, 1, 0);
    chk("lb_const", grf_wd, 32'hFFFF_FF80);
    step("lbu", 1, 1, 5'd9, 2'd1, 32'd0, 32'h80FF_7F01, 2'd2, 3'd4, 32'h3008, 32'd0, 1, 0);
    chk("lbu_const", grf_wd, 32'h0000_00FF);
    step("lh",  1, 1, 5'd10, 2'd1, 32'd0, 32'h80FF_7F01, 2'd2, 3'd1, 32'h300C, 32'd0, 1, 0);
    chk("lh_const", grf_wd, 32'hFFFF_80FF);
    step("lhu", 1, 1, 5'd11, 2'd1, 32'd0, 32'h80FF_7F01, 2'd0, 3'd2, 32'h3010, 32'd0, 1, 0);
    chk("lhu_const", grf_wd, 32'h0000_7F01);

    // Write to $0 is suppressed, then PC+8 (including 32-bit wrap)
    step("zero", 1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 2'd0, 3'd0, 32'h3014, 32'd0, 1, 0);
    chk("zero_we", {31'd0, grf_we}, 32'd0);
    step("pc8", 1, 1, 5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 3'd0, 32'h0000_3010, 32'd0, 1, 0);
    chk("pc8_const", grf_wd, 32'h0000_3018);
    step("pc8_wrap", 1, 1, 5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 3'd0, 32'hFFFF_FFFC, 32'd0, 1, 0);
    chk("pc8_wrap_const", grf_wd, 32'h0000_0004);
    step("hilo", 1, 1, 5'd3, 2'd3, 32'd0, 32'd0, 2'd0, 3'd0, 32'h3020, 32'hCAFE_F00D, 1, 0);

    // Hold for two cycles, then flush beats en
    step("hold1", 1, 1, 5'd4, 2'd0, 32'h1111_1111, 32'd0, 2'd0, 3'd0, 32'h4000, 32'd0, 0, 0);
    step("hold2", 1, 1, 5'd6, 2'd0, 32'h2222_2222, 32'd0, 2'd0, 3'd0, 32'h4004, 32'd0, 0, 0);
    chk("hold_wd", grf_wd, 32'hCAFE_F00D);
    step("flush", 1, 1, 5'd7, 2'd0, 32'h3333_3333, 32'd0, 2'd0, 3'd0, 32'h4008, 32'd0, 1, 1);
    chk("flush_pc", grf_pc, 32'h0000_3000);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step("rand", 1'($urandom), 1'($urandom), a, 2'($urandom), $urandom, $urandom,
           2'($urandom), 3'($urandom), $urandom, $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end

    // Counter wrap: 17 retirements after reset
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step("wrap", 1, 1, 5'(i + 1), 2'd0, 32'(i), 32'd0, 2'd0, 3'd0, 32'h5000 + 32'(4 * i), 32'd0, 1, 0);
    end
    chk("wrap_cnt4", {28'd0, retire_cnt_4}, 32'd1);
    chk("wrap_cnt32", retire_cnt, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- M/W pipeline register plus writeback-select logic for the P6 five-stage MIPS pipeline.
- Captures memory-stage results on posedge clk, extends and aligns load data, and selects the writeback value.
- Drives the register file write port: grf_a3, grf_wd, grf_we and grf_pc. The register file commits these on the following negedge.
- Also exports a W-stage forwarding view and a retired-instruction counter.

Parameters:
- PC_RESET, 32'h0000_3000, grf_pc value after reset or flush.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- en  input  1  capture enable; 0 holds the current W-stage contents.
- flush  input  1  synchronous bubble insert; takes priority over en.
- m_valid  input  1  M stage holds a real instruction.
- m_pc  input  32  PC of the M-stage instruction.
- m_we  input  1  instruction writes a GPR.
- m_a3  input  5  destination register.
- m_wd_sel  input  2  0=ALU, 1=MEM, 2=PC+8, 3=HI/LO.
- m_alu  input  32  ALU result.
- m_dm_rdata  input  32  raw aligned word read from data memory.
- m_addr_lo  input  2  byte offset of the load address.
- m_ld_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5-7 are treated as LW.
- m_hilo  input  32  HI/LO read value.
- grf_a3  output  5  write address to the register file.
- grf_wd  output  32  write data to the register file.
- grf_we  output  1  write enable to the register file.
- grf_pc  output  32  PC of the W-stage instruction.
- w_fwd_a3  output  5  forwarding destination; 0 when grf_we=0.
- w_fwd_wd  output  32  forwarding data; equals grf_wd.
- retire_cnt  output  CNT_W  count of valid instructions that reached W.

Behaviour:
- Reset (async, reset=0): all W registers clear.
  - grf_a3=0, grf_wd=0, grf_we=0, grf_pc=PC_RESET, w_fwd_a3=0, retire_cnt=0.
  - Outputs take these values without a clock edge. Release is synchronous to the next posedge.
- Posedge priority:
  - flush=1: load a bubble (valid=0, we=0, a3=0, data=0, pc=PC_RESET), regardless of en.
  - else en=1: capture all m_* inputs.
  - else: hold.
- Latency: an M-stage value appears on grf_* one cycle after the capturing posedge. It is committed to the register file at the negedge of that same cycle.
- grf_we = valid & we & (a3!=0). A write to $0 is suppressed here and is never presented to the register file.
- Load extension is applied to the registered raw word, combinationally from registers:
  - LW: the word.
  - LH/LHU: halfword [31:16] if addr_lo[1]=1, else [15:0]. addr_lo[0] is ignored. LH sign-extends; LHU zero-extends.
  - LB/LBU: byte at bits [8*addr_lo+7 : 8*addr_lo]. LB sign-extends; LBU zero-extends.
- WD mux (m_wd_sel):
  - 0: alu.
  - 1: extended load.
  - 2: pc+8, computed in 32-bit with wrap (0xFFFF_FFFC+8 = 0x0000_0004).
  - 3: hilo.
- Output timing: grf_wd/grf_a3/grf_we are stable for the entire cycle after posedge, so they meet the negedge write.
- retire_cnt increments by 1 on each posedge that captures m_valid=1 with flush=0 and en=1. It wraps modulo 2^CNT_W with no saturation. A held cycle does not increment.
- flush and en both high: flush wins, and the counter does not increment.
- reset asserted mid-cycle: outputs clear immediately; any pending negedge write sees grf_we=0.

Decomposition:
- Shared package pipe_pkg:
  - wd_sel encodings: WD_ALU, WD_MEM, WD_PC8, WD_HILO.
  - ld_type encodings: LD_W, LD_H, LD_HU, LD_B, LD_BU.
  - PC_RESET constant.
- One sub-module, load_ext: combinational byte/half select and extension. Inputs: raw word, addr_lo, ld_type. Output: 32-bit result.

Test Plan:
- Reset: drive reset=0 mid-cycle with grf_we=1 pending -> grf_we=0, grf_pc=0x3000, retire_cnt=0 immediately, with no clock edge.
- ALU write: m_we=1, a3=5, sel=ALU, alu=0x1234_5678, en=1 -> next cycle grf_a3=5, grf_wd=0x1234_5678, grf_we=1, retire_cnt=1.
- Loads with rdata=0x80FF_7F01:
  - LB, addr_lo=3 -> 0xFFFF_FF80.
  - LBU, addr_lo=2 -> 0x0000_00FF.
  - LH, addr_lo=2 -> 0xFFFF_80FF.
  - LHU, addr_lo=0 -> 0x0000_7F01.
- $0 and PC+8: a3=0, m_we=1 -> grf_we=0 and w_fwd_a3=0. Then sel=PC8, pc=0x0000_3010 -> grf_wd=0x0000_3018.
- Hold/flush: en=0 for 2 cycles -> outputs and retire_cnt unchanged. Then flush=1 with en=1 and m_valid=1 -> bubble loaded, grf_we=0, counter unchanged.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> retire_cnt=1.
